// File: rtl/nes_mem_arb_pkg.sv
// Shared types and constants for the NES unified-memory arbiter.
package nes_mem_arb_pkg;

   localparam int unsigned MEM_AW = 22;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_PPU = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACK
   } arb_state_e;

endpackage

// File: rtl/nes_mem_arb_starve_ctr.sv
// PPU-run counter: after MAX_PPU_RUN contested PPU grants the CPU gets the next one.
// Instantiated only when NES_MEM_ARB_FAIRNESS_EN is defined.
module nes_mem_arb_starve_ctr #(
   parameter int unsigned MAX_PPU_RUN = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic idle_i,
   input  logic cpu_req_i,
   input  logic grant_ppu_i,
   input  logic grant_cpu_i,
   output logic cpu_override_o
);

   localparam int unsigned CW = $clog2(MAX_PPU_RUN + 1);
   localparam logic [CW-1:0] RUN_MAX = CW'(MAX_PPU_RUN);

   logic [CW-1:0] run_q, run_d;

   always_comb begin
      run_d = run_q;
      if (grant_cpu_i || (idle_i && !cpu_req_i)) begin
         run_d = '0;
      end else if (grant_ppu_i && cpu_req_i && (run_q != RUN_MAX)) begin
         run_d = run_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         run_q <= '0;
      end else begin
         run_q <= run_d;
      end
   end

   assign cpu_override_o = (run_q == RUN_MAX);

endmodule

// File: rtl/nes_mem_arbiter.sv
// CPU/PPU arbiter for the single-port NES memory: grant, strobe, wait RD_LAT, ack.
// Define NES_MEM_ARB_FAIRNESS_EN to bound CPU starvation by MAX_PPU_RUN.
module nes_mem_arbiter
   import nes_mem_arb_pkg::*;
#(
   parameter int unsigned RD_LAT      = 2,
   parameter int unsigned MAX_PPU_RUN = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_done,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [MEM_AW-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   input  logic              ppu_req,
   input  logic              ppu_we,
   input  logic [MEM_AW-1:0] ppu_addr,
   input  logic [7:0]        ppu_wdata,
   output logic              ppu_ack,
   output logic [7:0]        ppu_rdata,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd_cpu,
   output logic              mem_rd_ppu,
   output logic              mem_wr,
   output logic [7:0]        mem_d,
   input  logic [7:0]        mem_q_cpu,
   input  logic [7:0]        mem_q_ppu,
   output logic              busy
);

   localparam int unsigned LW = $clog2(RD_LAT + 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

   arb_state_e        state_q, state_d;
   logic              who_q, who_d;
   logic              we_q, we_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [LW-1:0]     lat_q, lat_d;
   logic [7:0]        cpu_rdata_q, cpu_rdata_d;
   logic [7:0]        ppu_rdata_q, ppu_rdata_d;
   logic              grant;
   logic              cpu_override;
   logic              ppu_wins;

`ifdef NES_MEM_ARB_FAIRNESS_EN
   nes_mem_arb_starve_ctr #(
      .MAX_PPU_RUN (MAX_PPU_RUN)
   ) u_starve_ctr (
      .clk_i          (clock),
      .rst_ni         (reset),
      .idle_i         (state_q == IDLE),
      .cpu_req_i      (cpu_req),
      .grant_ppu_i    (grant && ppu_wins),
      .grant_cpu_i    (grant && !ppu_wins),
      .cpu_override_o (cpu_override)
   );
`else
   // Strict PPU priority; MAX_PPU_RUN has no effect in this build.
   assign cpu_override = 1'b0 && (MAX_PPU_RUN != 0);
`endif

   assign ppu_wins = ppu_req && !(cpu_req && cpu_override);

   always_comb begin
      state_d     = state_q;
      who_d       = who_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lat_d       = lat_q;
      cpu_rdata_d = cpu_rdata_q;
      ppu_rdata_d = ppu_rdata_q;
      grant       = 1'b0;
      mem_wr      = 1'b0;
      mem_rd_cpu  = 1'b0;
      mem_rd_ppu  = 1'b0;
      cpu_ack     = 1'b0;
      ppu_ack     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load_done && (cpu_req || ppu_req)) begin
               grant   = 1'b1;
               state_d = ISSUE;
               who_d   = ppu_wins ? REQ_PPU : REQ_CPU;
               we_d    = ppu_wins ? ppu_we : cpu_we;
               addr_d  = ppu_wins ? ppu_addr : cpu_addr;
               wdata_d = ppu_wins ? ppu_wdata : cpu_wdata;
            end
         end
         ISSUE: begin
            mem_wr     = we_q;
            mem_rd_cpu = !we_q && (who_q == REQ_CPU);
            mem_rd_ppu = !we_q && (who_q == REQ_PPU);
            lat_d      = LW'(1);
            state_d    = (!we_q && (RD_LAT > 1)) ? WAIT : ACK;
         end
         WAIT: begin
            if (lat_q == LAT_LAST) begin
               state_d = ACK;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         ACK: begin
            cpu_ack = (who_q == REQ_CPU);
            ppu_ack = (who_q == REQ_PPU);
            if (!we_q) begin
               if (who_q == REQ_CPU) cpu_rdata_d = mem_q_cpu;
               else                  ppu_rdata_d = mem_q_ppu;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         who_q       <= REQ_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lat_q       <= '0;
         cpu_rdata_q <= '0;
         ppu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         who_q       <= who_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         lat_q       <= lat_d;
         cpu_rdata_q <= cpu_rdata_d;
         ppu_rdata_q <= ppu_rdata_d;
      end
   end

   // Read data is forwarded straight from memory during the ack cycle and held afterwards.
   assign cpu_rdata = (cpu_ack && !we_q) ? mem_q_cpu : cpu_rdata_q;
   assign ppu_rdata = (ppu_ack && !we_q) ? mem_q_ppu : ppu_rdata_q;
   assign mem_addr  = addr_q;
   assign mem_d     = wdata_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Self-checking bench for nes_mem_arbiter: transaction-level model plus directed vectors.
module tb_nes_mem_arbiter;

   localparam int unsigned LAT  = 2;
   localparam int unsigned MAXR = 4;
`ifdef NES_MEM_ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_done = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [21:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        ppu_req = 1'b0, ppu_we = 1'b0;
   logic [21:0] ppu_addr = '0;
   logic [7:0]  ppu_wdata = '0;
   logic        cpu_ack, ppu_ack, mem_rd_cpu, mem_rd_ppu, mem_wr, busy;
   logic [7:0]  cpu_rdata, ppu_rdata, mem_d, mem_q_cpu, mem_q_ppu;
   logic [21:0] mem_addr;

   // second DUT, RD_LAT = 1
   logic        c2_req = 1'b0;
   logic [21:0] c2_addr = '0;
   logic        c2_ack, p2_ack, m2_rdc, m2_rdp, m2_wr, m2_busy;
   logic [7:0]  c2_rdata, p2_rdata, m2_d;
   logic [21:0] m2_addr;
   logic [7:0]  q2 = 8'hEE;

   always #5 clk = ~clk;

   nes_mem_arbiter #(.RD_LAT(LAT), .MAX_PPU_RUN(MAXR)) dut (
      .clock(clk), .reset(rst_n), .load_done(load_done),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
      .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
      .mem_addr(mem_addr), .mem_rd_cpu(mem_rd_cpu), .mem_rd_ppu(mem_rd_ppu),
      .mem_wr(mem_wr), .mem_d(mem_d), .mem_q_cpu(mem_q_cpu), .mem_q_ppu(mem_q_ppu),
      .busy(busy)
   );

   nes_mem_arbiter #(.RD_LAT(1), .MAX_PPU_RUN(MAXR)) dut_l1 (
      .clock(clk), .reset(rst_n), .load_done(load_done),
      .cpu_req(c2_req), .cpu_we(1'b0), .cpu_addr(c2_addr), .cpu_wdata(8'h00),
      .cpu_ack(c2_ack), .cpu_rdata(c2_rdata),
      .ppu_req(1'b0), .ppu_we(1'b0), .ppu_addr(22'h0), .ppu_wdata(8'h00),
      .ppu_ack(p2_ack), .ppu_rdata(p2_rdata),
      .mem_addr(m2_addr), .mem_rd_cpu(m2_rdc), .mem_rd_ppu(m2_rdp),
      .mem_wr(m2_wr), .mem_d(m2_d), .mem_q_cpu(q2), .mem_q_ppu(8'h00),
      .busy(m2_busy)
   );

   function automatic logic [7:0] cval(input logic [21:0] a);
      return a[7:0] ^ 8'h4A;
   endfunction
   function automatic logic [7:0] pval(input logic [21:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   // Memory: read data valid exactly LAT cycles after the strobe cycle, garbage otherwise.
   int          cyc = 0;
   int          cv_at = -100, pv_at = -100;
   logic [7:0]  cv = 8'h00, pv = 8'h00;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd_cpu) begin cv_at <= cyc + LAT; cv <= cval(mem_addr); end
      if (mem_rd_ppu) begin pv_at <= cyc + LAT; pv <= pval(mem_addr); end
      q2 <= m2_rdc ? 8'h3C : 8'hEE;
   end
   assign mem_q_cpu = (cyc == cv_at) ? cv : 8'hEE;
   assign mem_q_ppu = (cyc == pv_at) ? pv : 8'hEE;

   // Transaction model: an active transaction occupies cycles 1..len; strobe on 1, ack on len.
   bit          m_act = 1'b0, m_who = 1'b0, m_we = 1'b0;
   int          m_k = 0, m_run = 0;
   logic [21:0] m_addr = '0;
   logic [7:0]  m_d = '0, m_rc = '0, m_rp = '0;

   wire e_issue    = m_act && (m_k == 1);
   wire e_ack      = m_act && (m_k == (m_we ? 2 : 1 + LAT));
   wire m_ppu_wins = ppu_req && !(FAIR && cpu_req && (m_run == MAXR));

   always @(posedge clk) begin
      if (!rst_n) begin
         m_act <= 1'b0; m_k <= 0; m_who <= 1'b0; m_we <= 1'b0; m_run <= 0;
         m_addr <= '0; m_d <= '0; m_rc <= '0; m_rp <= '0;
      end else if (m_act) begin
         if (e_ack) begin
            m_act <= 1'b0;
            if (!m_we && !m_who) m_rc <= cval(m_addr);
            if (!m_we && m_who)  m_rp <= pval(m_addr);
         end else begin
            m_k <= m_k + 1;
         end
      end else begin
         if (load_done && (cpu_req || ppu_req)) begin
            m_act  <= 1'b1;
            m_k    <= 1;
            m_who  <= m_ppu_wins;
            m_we   <= m_ppu_wins ? ppu_we : cpu_we;
            m_addr <= m_ppu_wins ? ppu_addr : cpu_addr;
            m_d    <= m_ppu_wins ? ppu_wdata : cpu_wdata;
         end
         if (!cpu_req) m_run <= 0;
         else if (load_done) m_run <= m_ppu_wins ? ((m_run < MAXR) ? m_run + 1 : MAXR) : 0;
      end
   end

   int unsigned n_chk = 0, n_fail = 0;
   bit          chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, m_act);
         chk("mem_wr", mem_wr, e_issue && m_we);
         chk("mem_rd_cpu", mem_rd_cpu, e_issue && !m_we && !m_who);
         chk("mem_rd_ppu", mem_rd_ppu, e_issue && !m_we && m_who);
         chk("cpu_ack", cpu_ack, e_ack && !m_who);
         chk("ppu_ack", ppu_ack, e_ack && m_who);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_d", mem_d, m_d);
         chk("cpu_rdata", cpu_rdata, (e_ack && !m_who && !m_we) ? cval(m_addr) : m_rc);
         chk("ppu_rdata", ppu_rdata, (e_ack && m_who && !m_we) ? pval(m_addr) : m_rp);
      end
   end

   int          t0, t_str, t_ack, n_str, n_cack;
   logic        w_str;
   logic [21:0] a_str;
   logic [7:0]  d_str, r_ack;

   task automatic go(input logic ppu, input int budget);
      t_str = -1; t_ack = -1; n_str = 0; n_cack = 0; w_str = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (mem_wr || mem_rd_cpu || mem_rd_ppu) begin
            n_str++; t_str = cyc; w_str = mem_wr; a_str = mem_addr; d_str = mem_d;
         end
         if (cpu_ack) n_cack++;
         if (ppu ? ppu_ack : cpu_ack) begin
            t_ack = cyc;
            r_ack = ppu ? ppu_rdata : cpu_rdata;
            if (ppu) ppu_req = 1'b0; else cpu_req = 1'b0;
            break;
         end
      end
      if (t_ack < 0) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   logic [19:0] seq;
   int          k, n_c;

   initial begin
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_rdata", cpu_rdata, 0);

      // loader gating
      rst_n = 1'b1;
      cpu_addr = 22'h380010; cpu_we = 1'b0; cpu_req = 1'b1;
      repeat (4) @(negedge clk);
      chk("gate_busy", busy, 0);
      chk("gate_strobe", mem_rd_cpu, 0);
      load_done = 1'b1;
      t0 = cyc;
      go(1'b0, 20);
      chk("gate_strobe_cyc", t_str, t0 + 1);
      chk("gate_addr", a_str, 22'h380010);
      chk("gate_lat", t_ack - t_str, LAT);
      chk("gate_rdata", r_ack, 8'h5A);
      @(negedge clk);

      // PPU write
      ppu_addr = 22'h300123; ppu_wdata = 8'hC3; ppu_we = 1'b1; ppu_req = 1'b1;
      t0 = cyc;
      go(1'b1, 20);
      chk("pw_nstrobe", n_str, 1);
      chk("pw_is_write", w_str, 1);
      chk("pw_data", d_str, 8'hC3);
      chk("pw_addr", a_str, 22'h300123);
      chk("pw_ack_cyc", t_ack, t0 + 2);
      chk("pw_no_cpu_ack", n_cack, 0);
      repeat (2) @(negedge clk);

      // contention: 20 grants
      cpu_addr = 22'h000040; cpu_we = 1'b0; ppu_addr = 22'h200080; ppu_we = 1'b0;
      cpu_req = 1'b1; ppu_req = 1'b1;
      seq = '0; k = 0; n_c = 0;
      for (int i = 0; i < 400 && k < 20; i++) begin
         @(negedge clk);
         if (cpu_ack) n_c++;
         if (ppu_ack || cpu_ack) begin seq[k] = ppu_ack; k++; end
      end
      cpu_req = 1'b0; ppu_req = 1'b0;
      chk("cont_grants", k, 20);
      chk("cont_cpu_acks", n_c, FAIR ? 4 : 0);
      for (int j = 0; j < 20; j++) chk("cont_order", seq[j], FAIR ? (j % 5 != 4) : 1'b1);
      chk("cont_ppu_rdata", ppu_rdata, 8'h25);
      repeat (2) @(negedge clk);

      // reset during WAIT
      cpu_addr = 22'h0000AB; cpu_req = 1'b1;
      repeat (2) @(negedge clk);
      chk("rm_in_wait", busy, 1);
      chk("rm_wait_nostrobe", mem_rd_cpu, 0);
      rst_n = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      chk("rm_idle", busy, 0);
      chk("rm_no_ack", cpu_ack, 0);
      chk("rm_no_strobe", mem_rd_cpu | mem_rd_ppu | mem_wr, 0);
      chk("rm_addr", mem_addr, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cpu_req = 1'b1;
      t0 = cyc;
      go(1'b0, 20);
      chk("rm_fresh_ack_cyc", t_ack, t0 + 1 + LAT);
      chk("rm_fresh_rdata", r_ack, 8'hE1);
      @(negedge clk);

      // RD_LAT = 1 instance
      c2_addr = 22'h000077; c2_req = 1'b1;
      @(negedge clk);
      chk("l1_issue", m2_rdc, 1);
      chk("l1_noack", c2_ack, 0);
      @(negedge clk);
      chk("l1_ack", c2_ack, 1);
      chk("l1_rdata", c2_rdata, 8'h3C);
      c2_req = 1'b0;
      @(negedge clk);
      chk("l1_idle", m2_busy, 0);
      chk("l1_rdata_hold", c2_rdata, 8'h3C);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

endmodule
